// File: rtl/ibex_ex_issue_ctrl.sv
// Issue controller on the ID side of the EX interface: sequences ALU/MUL/DIV ops,
// holds multdiv results until writeback accepts them, and owns the intermediate registers.
module ibex_ex_issue_ctrl #(
  parameter int ImdW        = 34,
  parameter int MaxExCycles = 40
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_valid_i,
  input  logic                instr_is_mult_i,
  input  logic                instr_is_div_i,
  input  logic                instr_kill_i,
  input  logic                wb_ready_i,
  input  logic                ex_valid_i,
  input  logic [1:0]          imd_val_we_i,
  input  logic [2*ImdW-1:0]   imd_val_d_i,
  output logic [2*ImdW-1:0]   imd_val_q_o,
  output logic                alu_instr_first_cycle_o,
  output logic                mult_sel_o,
  output logic                div_sel_o,
  output logic                mult_en_o,
  output logic                div_en_o,
  output logic                multdiv_ready_id_o,
  output logic                instr_done_o,
  output logic                ex_busy_o,
  output logic                timeout_err_o
);

  localparam int CntW = $clog2(MaxExCycles + 1);

  typedef enum logic [1:0] {IDLE, MULTI, WAIT_WB} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ImdW-1:0] imd0_q, imd1_q;

  logic active;
  logic is_div;
  logic is_mul;
  logic cnt_last;
  logic timeout;

  // Reset gating keeps every combinational output quiet while rst_i is high.
  assign active   = instr_valid_i & ~instr_kill_i & ~rst_i;
  assign is_div   = instr_is_div_i;
  assign is_mul   = instr_is_mult_i & ~instr_is_div_i;
  assign cnt_last = (cnt_q == CntW'(MaxExCycles - 1));
  assign timeout  = (state_q == MULTI) & active & ~ex_valid_i & cnt_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (active) begin
          if (ex_valid_i) begin
            state_d = wb_ready_i ? IDLE : WAIT_WB;
          end else begin
            state_d = MULTI;
            cnt_d   = CntW'(1);
          end
        end
      end
      MULTI: begin
        if (active) begin
          if (ex_valid_i) begin
            state_d = wb_ready_i ? IDLE : WAIT_WB;
          end else if (cnt_last) begin
            state_d = IDLE;
          end else begin
            state_d = MULTI;
            cnt_d   = (cnt_q == CntW'(MaxExCycles)) ? cnt_q : cnt_q + CntW'(1);
          end
        end
      end
      WAIT_WB: begin
        if (active && !wb_ready_i) begin
          state_d = WAIT_WB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_instr_first_cycle_o = 1'b0;
    multdiv_ready_id_o      = 1'b1;
    instr_done_o            = 1'b0;
    timeout_err_o           = 1'b0;
    mult_sel_o              = active & is_mul;
    div_sel_o               = active & is_div;
    // The watchdog cycle drops the enables so multdiv abandons the op.
    mult_en_o               = active & is_mul & ~timeout;
    div_en_o                = active & is_div & ~timeout;
    ex_busy_o               = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        alu_instr_first_cycle_o = active;
        instr_done_o            = active & ex_valid_i & wb_ready_i;
      end
      MULTI: begin
        instr_done_o  = active & ex_valid_i & wb_ready_i;
        timeout_err_o = timeout;
      end
      WAIT_WB: begin
        multdiv_ready_id_o = wb_ready_i;
        instr_done_o       = active & wb_ready_i;
      end
      default: ;
    endcase
  end

  // Intermediate lanes are written only for a live instruction and survive kill/done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      imd0_q <= '0;
      imd1_q <= '0;
    end else begin
      if (imd_val_we_i[0] && active) imd0_q <= imd_val_d_i[ImdW-1:0];
      if (imd_val_we_i[1] && active) imd1_q <= imd_val_d_i[2*ImdW-1:ImdW];
    end
  end

  assign imd_val_q_o = {imd1_q, imd0_q};

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// Scoreboard bench for ibex_ex_issue_ctrl: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_ibex_ex_issue_ctrl;
  localparam int ImdW = 34;
  localparam int MaxC = 40;
  localparam int EW   = 9 + 2 * ImdW;

  logic              clk_i;
  logic              rst_i;
  logic              instr_valid_i, instr_is_mult_i, instr_is_div_i, instr_kill_i;
  logic              wb_ready_i, ex_valid_i;
  logic [1:0]        imd_val_we_i;
  logic [2*ImdW-1:0] imd_val_d_i;
  logic [2*ImdW-1:0] imd_val_q_o;
  logic              alu_instr_first_cycle_o, mult_sel_o, div_sel_o, mult_en_o, div_en_o;
  logic              multdiv_ready_id_o, instr_done_o, ex_busy_o, timeout_err_o;

  ibex_ex_issue_ctrl #(.ImdW(ImdW), .MaxExCycles(MaxC)) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .instr_valid_i           (instr_valid_i),
    .instr_is_mult_i         (instr_is_mult_i),
    .instr_is_div_i          (instr_is_div_i),
    .instr_kill_i            (instr_kill_i),
    .wb_ready_i              (wb_ready_i),
    .ex_valid_i              (ex_valid_i),
    .imd_val_we_i            (imd_val_we_i),
    .imd_val_d_i             (imd_val_d_i),
    .imd_val_q_o             (imd_val_q_o),
    .alu_instr_first_cycle_o (alu_instr_first_cycle_o),
    .mult_sel_o              (mult_sel_o),
    .div_sel_o               (div_sel_o),
    .mult_en_o               (mult_en_o),
    .div_en_o                (div_en_o),
    .multdiv_ready_id_o      (multdiv_ready_id_o),
    .instr_done_o            (instr_done_o),
    .ex_busy_o               (ex_busy_o),
    .timeout_err_o           (timeout_err_o)
  );

  // Starting high makes the first edge a negedge, so cycle 0 is sampled before any posedge.
  initial clk_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [EW-1:0]     exp_q[$];
  string             nm_q[$];
  logic [2*ImdW-1:0] exp_imd;
  int                checks = 0;
  int                errors = 0;

  logic [EW-1:0] mon_exp, mon_got;
  string         mon_nm;

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = nm_q.pop_front();
      mon_got = {alu_instr_first_cycle_o, mult_sel_o, div_sel_o, mult_en_o, div_en_o,
                 multdiv_ready_id_o, instr_done_o, ex_busy_o, timeout_err_o, imd_val_q_o};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s @%0t got ctrl=%b imd=%h exp ctrl=%b imd=%h", mon_nm, $time,
                 mon_got[EW-1 -: 9], mon_got[2*ImdW-1:0], mon_exp[EW-1 -: 9], mon_exp[2*ImdW-1:0]);
      end
    end
  end

  // Bit order: first, mult_sel, div_sel, mult_en, div_en, ready_id, done, busy, timeout.
  function automatic logic [8:0] E(input logic f, ms, ds, me, de, rd, dn, bz, to);
    return {f, ms, ds, me, de, rd, dn, bz, to};
  endfunction

  task automatic drv(input logic v, m, d, k, ex, wb, input logic [1:0] we,
                     input logic [2*ImdW-1:0] dat);
    instr_valid_i   = v;
    instr_is_mult_i = m;
    instr_is_div_i  = d;
    instr_kill_i    = k;
    ex_valid_i      = ex;
    wb_ready_i      = wb;
    imd_val_we_i    = we;
    imd_val_d_i     = dat;
  endtask

  task automatic cyc(input string nm, input logic [8:0] c);
    exp_q.push_back({c, exp_imd});
    nm_q.push_back(nm);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input string nm);
    drv(0, 0, 0, 0, 0, 0, 2'b00, '0);
    cyc(nm, E(0, 0, 0, 0, 0, 1, 0, 0, 0));
  endtask

  localparam logic [2*ImdW-1:0] ONES = {2*ImdW{1'b1}};

  initial begin
    rst_i   = 1'b1;
    exp_imd = '0;
    // Reset dominates live-looking inputs and imd writes.
    drv(1, 1, 0, 0, 1, 1, 2'b11, ONES);
    cyc("rst0", E(0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("rst1", E(0, 0, 0, 0, 0, 1, 0, 0, 0));
    rst_i = 1'b0;
    idle("post_rst");

    drv(1, 0, 0, 0, 1, 1, 2'b00, '0);
    cyc("alu0", E(1, 0, 0, 0, 0, 1, 1, 0, 0));
    cyc("alu_b2b", E(1, 0, 0, 0, 0, 1, 1, 0, 0));
    idle("alu_idle");

    // DIV with MUL also decoded: DIV wins, result on cycle 37.
    for (int c = 0; c <= 37; c++) begin
      drv(1, 1, 1, 0, (c == 37), 1, 2'b00, '0);
      cyc("div37", E((c == 0), 0, 1, 0, 1, 1, (c == 37), (c != 0), 0));
    end
    idle("div_idle");

    drv(1, 1, 0, 0, 0, 0, 2'b00, '0);
    cyc("mul_iss", E(1, 1, 0, 1, 0, 1, 0, 0, 0));
    drv(1, 1, 0, 0, 1, 0, 2'b00, '0);
    cyc("mul_exv", E(0, 1, 0, 1, 0, 1, 0, 1, 0));
    for (int c = 0; c < 3; c++) begin
      drv(1, 1, 0, 0, 0, 0, 2'b00, '0);
      cyc("mul_wait", E(0, 1, 0, 1, 0, 0, 0, 1, 0));
    end
    drv(1, 1, 0, 0, 0, 1, 2'b00, '0);
    cyc("mul_done", E(0, 1, 0, 1, 0, 1, 1, 1, 0));
    idle("mul_idle");

    drv(1, 0, 0, 0, 0, 1, 2'b01, {34'h0, 34'h2_DEAD_BEEF});
    cyc("imd_w0", E(1, 0, 0, 0, 0, 1, 0, 0, 0));
    exp_imd[ImdW-1:0] = 34'h2_DEAD_BEEF;
    drv(1, 0, 0, 0, 0, 1, 2'b10, {34'h1_2345_6789, 34'h0});
    cyc("imd_w1", E(0, 0, 0, 0, 0, 1, 0, 1, 0));
    exp_imd[2*ImdW-1:ImdW] = 34'h1_2345_6789;
    drv(1, 0, 0, 1, 0, 1, 2'b11, ONES);
    cyc("imd_kill", E(0, 0, 0, 0, 0, 1, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 1, 2'b11, ONES);
    cyc("imd_novld", E(0, 0, 0, 0, 0, 1, 0, 0, 0));
    idle("imd_keep");

    for (int c = 0; c < 5; c++) begin
      drv(1, 1, 0, 0, 0, 1, 2'b00, '0);
      cyc("kmul", E((c == 0), 1, 0, 1, 0, 1, 0, (c != 0), 0));
    end
    drv(1, 1, 0, 1, 1, 1, 2'b00, '0);
    cyc("kill5", E(0, 0, 0, 0, 0, 1, 0, 1, 0));
    drv(1, 0, 0, 0, 1, 1, 2'b00, '0);
    cyc("after_kill", E(1, 0, 0, 0, 0, 1, 1, 0, 0));
    idle("kill_idle");

    for (int c = 0; c < MaxC; c++) begin
      drv(1, 0, 1, 0, 0, 1, 2'b00, '0);
      cyc("tmo", E((c == 0), 0, 1, 0, (c != MaxC - 1), 1, 0, (c != 0), (c == MaxC - 1)));
    end
    idle("tmo_idle");

    drv(1, 1, 0, 0, 1, 0, 2'b00, '0);
    cyc("ww_iss", E(1, 1, 0, 1, 0, 1, 0, 0, 0));
    drv(1, 1, 0, 1, 0, 1, 2'b00, '0);
    cyc("ww_kill", E(0, 0, 0, 0, 0, 1, 0, 1, 0));
    idle("ww_idle");

    drv(1, 0, 1, 0, 0, 1, 2'b11, {34'h0_AAAA, 34'h0_5555});
    cyc("ar_iss", E(1, 0, 1, 0, 1, 1, 0, 0, 0));
    exp_imd = {34'h0_AAAA, 34'h0_5555};
    drv(1, 0, 1, 0, 0, 1, 2'b00, '0);
    cyc("ar_multi", E(0, 0, 1, 0, 1, 1, 0, 1, 0));
    rst_i = 1'b1;
    #1;
    exp_imd = '0;
    cyc("ar_rst", E(0, 0, 0, 0, 0, 1, 0, 0, 0));
    rst_i = 1'b0;
    idle("ar_after");

    repeat (5) @(posedge clk_i);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
